// File: rtl/sqrt_accel_pkg.sv
// Shared types and constants for the sqrt_accel square-root coprocessor.
// The rounding mode is selected elsewhere by the SQRT_ROUND_EN macro.
package sqrt_accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RD_HI = 3'd2,
        ST_RD_LO = 3'd3,
        ST_CALC  = 3'd4,
        ST_ROUND = 3'd5,
        ST_WR    = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam int SQRT_ITERS = 8;
    localparam int OPND_BYTES = 2;
    localparam int OPND_W     = OPND_BYTES * 8;
    localparam int REM_W      = 10;
    localparam int ROOT_W     = 8;
    localparam int ADDR_W     = 8;

    localparam logic [ADDR_W-1:0] OPND_ADDR    = 8'd16;
    localparam logic [ADDR_W-1:0] OPND_LO_ADDR = 8'd17;
    localparam logic [ADDR_W-1:0] RSLT_ADDR    = 8'd18;

    localparam logic [2:0] LAST_ITER = 3'(SQRT_ITERS - 1);

endpackage

// File: rtl/sqrt_accel_step.sv
// One restoring digit-by-digit square-root iteration (two operand bits in,
// one root bit out). Purely combinational; the top reuses it every CALC cycle.
module sqrt_step
    import sqrt_accel_pkg::*;
(
    input  logic [REM_W-1:0]  rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        pair,
    output logic [REM_W-1:0]  rem_next,
    output logic [ROOT_W-1:0] root_next
);

    logic [REM_W+1:0] trial_s;
    logic [REM_W+1:0] divisor_s;
    logic [REM_W+1:0] diff_s;

    // Trial subtraction of {root,01} from the shifted remainder
    always_comb begin
        trial_s   = {rem, pair};
        divisor_s = {2'b00, root, 2'b01};
        diff_s    = trial_s - divisor_s;
        if (trial_s >= divisor_s) begin
            rem_next  = REM_W'(diff_s);
            root_next = (root << 1) | 8'd1;
        end else begin
            rem_next  = REM_W'(trial_s);
            root_next = root << 1;
        end
    end

endmodule

// File: rtl/sqrt_accel.sv
// Square-root coprocessor: reads a 16-bit operand from data memory after the
// host Start/Ack launch, writes the 8-bit root back. SQRT_ROUND_EN selects
// round-to-nearest; otherwise the floor root is written.
module sqrt_accel
    import sqrt_accel_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWrEn,
    output logic [7:0]        MemWrData,
    input  logic [7:0]        MemRdData
);

    state_t              state_r;
    logic [OPND_W-1:0]   opnd_r;
    logic [REM_W-1:0]    rem_r;
    logic [ROOT_W-1:0]   root_r;
    logic [2:0]          iter_r;
    logic                ack_r;
    logic                busy_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_wren_r;
    logic [7:0]          mem_wrdata_r;

    logic [REM_W-1:0]    rem_next_s;
    logic [ROOT_W-1:0]   root_next_s;
    logic [ROOT_W-1:0]   root_rnd_s;

    sqrt_step u_step (
        .rem       (rem_r),
        .root      (root_r),
        .pair      (opnd_r[OPND_W-1:OPND_W-2]),
        .rem_next  (rem_next_s),
        .root_next (root_next_s)
    );

    // Final root adjustment; rem>root means the true root is past the half step
    always_comb begin
`ifdef SQRT_ROUND_EN
        if ((rem_r > REM_W'(root_r)) && (root_r != 8'hFF)) begin
            root_rnd_s = root_r + 8'd1;
        end else begin
            root_rnd_s = root_r;
        end
`else
        root_rnd_s = root_r;
`endif
    end

    // Control FSM with registered memory strobes and handshake outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            opnd_r       <= 16'd0;
            rem_r        <= 10'd0;
            root_r       <= 8'd0;
            iter_r       <= 3'd0;
            ack_r        <= 1'b0;
            busy_r       <= 1'b0;
            mem_addr_r   <= 8'd0;
            mem_wren_r   <= 1'b0;
            mem_wrdata_r <= 8'd0;
        end else begin
            mem_addr_r   <= 8'd0;
            mem_wren_r   <= 1'b0;
            mem_wrdata_r <= 8'd0;
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        state_r <= ST_ARM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (!Start) begin
                        state_r    <= ST_RD_HI;
                        busy_r     <= 1'b1;
                        mem_addr_r <= OPND_ADDR;
                    end else begin
                        state_r <= ST_ARM;
                    end
                end
                ST_RD_HI: begin
                    opnd_r[15:8] <= MemRdData;
                    mem_addr_r   <= OPND_LO_ADDR;
                    state_r      <= ST_RD_LO;
                end
                ST_RD_LO: begin
                    opnd_r[7:0] <= MemRdData;
                    rem_r       <= 10'd0;
                    root_r      <= 8'd0;
                    iter_r      <= 3'd0;
                    state_r     <= ST_CALC;
                end
                ST_CALC: begin
                    // Operand shifts left so the next pair is always at the top
                    rem_r  <= rem_next_s;
                    root_r <= root_next_s;
                    opnd_r <= {opnd_r[OPND_W-3:0], 2'b00};
                    iter_r <= iter_r + 3'd1;
                    if (iter_r == LAST_ITER) begin
                        state_r <= ST_ROUND;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_ROUND: begin
                    root_r       <= root_rnd_s;
                    mem_addr_r   <= RSLT_ADDR;
                    mem_wren_r   <= 1'b1;
                    mem_wrdata_r <= root_rnd_s;
                    state_r      <= ST_WR;
                end
                ST_WR: begin
                    busy_r  <= 1'b0;
                    ack_r   <= 1'b1;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    if (Start) begin
                        ack_r   <= 1'b0;
                        state_r <= ST_ARM;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    iter_r  <= 3'd0;
                end
            endcase
        end
    end

    assign Ack       = ack_r;
    assign Busy      = busy_r;
    assign MemAddr   = mem_addr_r;
    assign MemWrEn   = mem_wren_r;
    assign MemWrData = mem_wrdata_r;

endmodule

// File: tb/tb_sqrt_accel.sv
// Directed self-checking bench for sqrt_accel with a byte-wide memory model
// shared between host preload writes and coprocessor result writes.
module tb_sqrt_accel;

`ifdef SQRT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic       Busy;
    logic [7:0] MemAddr;
    logic       MemWrEn;
    logic [7:0] MemWrData;
    logic [7:0] MemRdData;

    logic [7:0] core [0:255];
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_data;

    int tests;
    int fails;

    sqrt_accel dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Ack       (Ack),
        .Busy      (Busy),
        .MemAddr   (MemAddr),
        .MemWrEn   (MemWrEn),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign MemRdData = core[MemAddr];

    always @(posedge Clk) begin
        if (MemWrEn) core[MemAddr] <= MemWrData;
        else if (host_we) core[host_addr] <= host_data;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hwrite(input logic [7:0] a, input logic [7:0] d);
        host_we   = 1'b1;
        host_addr = a;
        host_data = d;
        tick();
        host_we = 1'b0;
    endtask

    // Start high for the two preload cycles
    task automatic preload(input logic [15:0] v);
        Start = 1'b1;
        hwrite(8'd16, v[15:8]);
        hwrite(8'd17, v[7:0]);
    endtask

    // Drop Start, wait for Ack (bounded), check latency, write strobe and result
    task automatic go(input logic [7:0] exp, input string tag, input bit hold);
        int lat;
        int nwr;
        logic [7:0] wr_addr;
        lat = 0;
        nwr = 0;
        wr_addr = 8'd0;
        Start = 1'b0;
        tick();
        check({tag, "_busy"}, {15'd0, Busy}, 16'd1);
        if (hold) Start = 1'b1;
        while (lat < 40 && !Ack) begin
            tick();
            lat++;
            if (MemWrEn) begin
                nwr++;
                wr_addr = MemAddr;
            end
        end
        check({tag, "_lat"}, 16'(lat), 16'd12);
        check({tag, "_nwr"}, 16'(nwr), 16'd1);
        check({tag, "_waddr"}, {8'd0, wr_addr}, 16'd18);
        check({tag, "_res"}, {8'd0, core[18]}, {8'd0, exp});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Reset = 1'b0;
        Start = 1'b0;
        host_we = 1'b0;
        host_addr = 8'd0;
        host_data = 8'd0;
        for (int i = 0; i < 256; i++) core[i] = 8'd0;

        repeat (2) tick();
        check("rst_ack", {15'd0, Ack}, 16'd0);
        check("rst_busy", {15'd0, Busy}, 16'd0);
        check("rst_addr", {8'd0, MemAddr}, 16'd0);
        check("rst_wren", {15'd0, MemWrEn}, 16'd0);
        check("rst_wdata", {8'd0, MemWrData}, 16'd0);

        Reset = 1'b1;
        repeat (3) tick();
        check("nolaunch_busy", {15'd0, Busy}, 16'd0);
        check("nolaunch_ack", {15'd0, Ack}, 16'd0);

        preload(16'd81);    go(8'h09, "op81", 1'b0);
        preload(16'd91);    go(RND ? 8'h0A : 8'h09, "op91", 1'b0);
        preload(16'd90);    go(8'h09, "op90", 1'b0);
        preload(16'd2);     go(8'h01, "op2", 1'b0);
        preload(16'd3);     go(RND ? 8'h02 : 8'h01, "op3", 1'b0);
        preload(16'd0);     go(8'h00, "op0", 1'b0);
        preload(16'd65535); go(8'hFF, "op65535", 1'b0);
        preload(16'd65025); go(8'hFF, "op65025", 1'b0);

        // Back-to-back: Ack must drop one cycle after Start is raised
        Start = 1'b1;
        tick();
        check("b2b_ackdrop", {15'd0, Ack}, 16'd0);
        preload(16'd16);    go(8'h04, "b2b16", 1'b0);

        // Reset during CALC cancels the job before any write
        hwrite(8'd18, 8'h5A);
        preload(16'd200);
        Start = 1'b0;
        tick();
        repeat (4) tick();
        Reset = 1'b0;
        #1;
        check("midrst_ack", {15'd0, Ack}, 16'd0);
        check("midrst_busy", {15'd0, Busy}, 16'd0);
        check("midrst_wren", {15'd0, MemWrEn}, 16'd0);
        repeat (2) tick();
        check("midrst_mem", {8'd0, core[18]}, 16'h005A);
        Reset = 1'b1;
        tick();
        preload(16'd144);   go(8'h0C, "after_rst", 1'b0);

        // Start held high through the job: single-cycle Ack, then re-armed
        Start = 1'b1;
        tick();
        preload(16'd49);    go(8'h07, "held", 1'b1);
        tick();
        check("held_ackpulse", {15'd0, Ack}, 16'd0);
        check("held_busy", {15'd0, Busy}, 16'd0);
        repeat (2) tick();
        check("held_noreack", {15'd0, Ack}, 16'd0);
        preload(16'd25);    go(8'h05, "relaunch", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
